attex_bus_ctrl: RTL and testbench
=================================

Name: attex_bus_ctrl

Overview:
Sequences every SCC68070 bus cycle in the CD-i MONO1 system. It decodes the address into one-hot target selects (MCD212, CDIC, slave uC, NVRAM) and inserts wait states or waits for the target handshake. It generates the CPU bus_ack / bus_err responses, watchdogs unanswered cycles, and produces the delayed slave-uC interrupt pulse. It sits between scc68070 and the peripheral instances in cditop, replacing the ad-hoc combinational ack/cs logic.

Parameters:
FIXED_WAIT, 2, wait cycles inserted before ack for CDIC and NVRAM (0..15)
TIMEOUT, 255, cycles without target ack before bus_err (8-bit counter)
IRQ_DELAY, 20, cycles from slave-cycle start to slave_irq pulse (8-bit, >=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
as  in  1  CPU address strobe
uds  in  1  CPU upper data strobe
lds  in  1  CPU lower data strobe
write_strobe  in  1  CPU write (1) / read (0)
addr  in  23  CPU word address [23:1]
mcd212_ack  in  1  MCD212 cycle-complete level
dtackslaven  in  1  slave uC DTACK line, effective level after DDR masking
cs_mcd212  out  1  select, held for whole cycle
cs_cdic  out  1  select
cs_slave  out  1  select
cs_nvram  out  1  select
bus_ack  out  1  one-cycle cycle-complete pulse to CPU
bus_err  out  1  one-cycle bus error pulse to CPU
slave_irq  out  1  one-cycle interrupt pulse to slave uC

Behaviour:
- Reset (reset low, async): state IDLE; all cs_*, bus_ack, bus_err, slave_irq = 0; counters 0; dtackslaven_q = 1.
- Decode on byte address A={addr,0}; priority order:
  ERRMAP: 0x600000<=A<0xD00000 or A>=0xF00000
  CDIC: A[23:16]=0x30
  SLAVE: A[23:16]=0x31
  NVRAM: A[23:16]=0x32
  MCD212: (A<=0x27FFFF or A>=0x400000) and addr[23]=0
  NONE: anything else
- A cycle starts when as=1 and (uds or lds)=1 in IDLE.
- FSM:
  - IDLE -> DECODE on cycle start; latch decode result.
  - DECODE, one cycle; the matching cs_* rises at its end:
    - ERRMAP -> ERR
    - CDIC/NVRAM -> WAIT_FIX, counter=FIXED_WAIT
    - SLAVE -> WAIT_SLV
    - MCD212 -> WAIT_ACK
    - NONE -> WAIT_ACK with no cs asserted
  - WAIT_FIX: counter decrements; at 0 -> ACK.
  - WAIT_SLV: -> ACK on dtackslaven rising edge (dtackslaven=1 and dtackslaven_q=0). A level already high on entry does not ack.
  - WAIT_ACK: -> ACK when mcd212_ack=1 and cs_mcd212=1.
  - Timeout applies in WAIT_ACK and WAIT_SLV: cycle counter cleared on DECODE entry and incremented each wait cycle; reaching TIMEOUT -> ERR. If ack and timeout occur in the same cycle, ack wins.
  - ACK: bus_ack=1 for exactly this cycle -> DONE.
  - ERR: bus_err=1 for exactly this cycle -> DONE.
  - DONE: cs_* held until as=0, then cleared -> IDLE. No new cycle is accepted until as has been low for at least one cycle.
- as falling in DECODE or any WAIT state (aborted cycle): -> IDLE next cycle; cs_* cleared; no ack, no err.
- Latency: MCD212 ack visible 1 cycle after mcd212_ack; CDIC/NVRAM bus_ack 2+FIXED_WAIT cycles after cycle start.
- slave_irq: 8-bit counter loaded with IRQ_DELAY on cs_slave rising edge; otherwise decrements toward 0 and stops there. slave_irq=1 in the cycle where the counter equals 1. A reload while counting restarts the delay and produces a single pulse only.
- bus_ack and bus_err are never both 1; at most one cs_* is 1.

Test Plan:
- CDIC read A=0x300010, FIXED_WAIT=2 -> cs_cdic high from cycle 2, bus_ack pulse at cycle 4, cs_cdic drops 1 cycle after as falls.
- MCD212 access A=0x000400, mcd212_ack raised 5 cycles later -> single bus_ack 1 cycle after ack; A=0x280000 -> no cs, bus_err after TIMEOUT=255 wait cycles.
- Slave access A=0x310002 with dtackslaven already 1, then 0 then 1 -> no ack on the initial high; bus_ack 1 cycle after the rising edge. slave_irq pulses exactly IRQ_DELAY=20 cycles after cs_slave rises.
- A=0x700000 and A=0xF00000 -> bus_err pulse 2 cycles after start, no cs asserted, no bus_ack.
- as deasserted mid-WAIT_ACK -> IDLE next cycle, no ack/err. Reset asserted mid-WAIT_FIX -> all outputs 0 immediately (asynchronous).
- mcd212_ack rises in the same cycle the timeout count is reached -> bus_ack only, bus_err stays 0.

Source files
------------

// File: rtl/attex_bus_ctrl.sv
// attex_bus_ctrl: SCC68070 bus-cycle sequencer for CD-i MONO1 (target decode, wait states, ack/err, slave irq)
module attex_bus_ctrl #(
    parameter int FIXED_WAIT = 2,
    parameter int TIMEOUT    = 255,
    parameter int IRQ_DELAY  = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as,
    input  logic        uds,
    input  logic        lds,
    input  logic        write_strobe,
    input  logic [23:1] addr,
    input  logic        mcd212_ack,
    input  logic        dtackslaven,
    output logic        cs_mcd212,
    output logic        cs_cdic,
    output logic        cs_slave,
    output logic        cs_nvram,
    output logic        bus_ack,
    output logic        bus_err,
    output logic        slave_irq
);
    typedef enum logic [2:0] {IDLE, DECODE, WAIT_FIX, WAIT_SLV, WAIT_ACK, ACK, ERR, DONE} state_t;
    typedef enum logic [2:0] {T_NONE, T_ERR, T_CDIC, T_SLV, T_NVR, T_MCD} tgt_t;

    state_t      state_q;
    tgt_t        tgt_q, tgt_d;
    logic [3:0]  cs_q, cs_sel;
    logic [3:0]  wait_q;
    logic [7:0]  tmo_q, irq_cnt_q;
    logic        ack_q, err_q, dtack_q, cs_slave_prev_q, hit;
    logic [23:0] a;
    logic        unused_write;

    assign a            = {addr, 1'b0};
    assign unused_write = write_strobe;
    assign cs_sel       = {tgt_q == T_MCD, tgt_q == T_CDIC, tgt_q == T_SLV, tgt_q == T_NVR};
    assign hit          = (state_q == WAIT_SLV) ? (dtackslaven && !dtack_q) : (mcd212_ack && cs_q[3]);
    assign {cs_mcd212, cs_cdic, cs_slave, cs_nvram} = cs_q;
    assign bus_ack      = ack_q;
    assign bus_err      = err_q;
    assign slave_irq    = irq_cnt_q == 8'd1;

    // Byte-address decode, first matching region wins
    always_comb begin
        tgt_d = ((a >= 24'h600000 && a < 24'hD00000) || a >= 24'hF00000) ? T_ERR :
                (a[23:16] == 8'h30) ? T_CDIC :
                (a[23:16] == 8'h31) ? T_SLV :
                (a[23:16] == 8'h32) ? T_NVR :
                ((a <= 24'h27FFFF || a >= 24'h400000) && !addr[23]) ? T_MCD : T_NONE;
    end

    // Bus-cycle sequencer; selects and responses are registered here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tgt_q   <= T_NONE;
            wait_q  <= '0;
            tmo_q   <= '0;
            cs_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (as && (uds || lds)) begin
                    state_q <= DECODE;
                    tgt_q   <= tgt_d;
                    tmo_q   <= '0;
                end
                DECODE: if (!as) begin
                    state_q <= IDLE;
                end else begin
                    cs_q <= cs_sel;
                    case (tgt_q)
                        T_ERR: begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                        T_CDIC, T_NVR: if (FIXED_WAIT == 0) begin
                            state_q <= ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= WAIT_FIX;
                            wait_q  <= 4'(FIXED_WAIT - 1);
                        end
                        T_SLV:   state_q <= WAIT_SLV;
                        default: state_q <= WAIT_ACK;
                    endcase
                end
                WAIT_FIX: if (!as) begin
                    state_q <= IDLE;
                    cs_q    <= '0;
                end else if (wait_q == 4'd0) begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                end else begin
                    wait_q <= wait_q - 4'd1;
                end
                WAIT_SLV, WAIT_ACK: if (!as) begin
                    state_q <= IDLE;
                    cs_q    <= '0;
                end else if (hit) begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    state_q <= ERR;
                    err_q   <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 8'd1;
                end
                ACK, ERR: state_q <= DONE;
                DONE: if (!as) begin
                    state_q <= IDLE;
                    cs_q    <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // DTACK edge history and slave interrupt delay (reload on cs_slave rise, count down to 0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dtack_q         <= 1'b1;
            cs_slave_prev_q <= 1'b0;
            irq_cnt_q       <= '0;
        end else begin
            dtack_q         <= dtackslaven;
            cs_slave_prev_q <= cs_q[1];
            irq_cnt_q       <= (cs_q[1] && !cs_slave_prev_q) ? 8'(IRQ_DELAY) :
                               (irq_cnt_q == 8'd0) ? 8'd0 : irq_cnt_q - 8'd1;
        end
    end
endmodule

// File: tb/tb_attex_bus_ctrl.sv
// tb_attex_bus_ctrl: randomized and directed bus cycles checked against a transaction-level reference model
module tb_attex_bus_ctrl;
    localparam int FW = 2, TMO = 255, IRQD = 20;

    logic        clk = 1'b0, reset = 1'b0, as = 1'b0, uds = 1'b0, lds = 1'b0, write_strobe = 1'b0;
    logic [23:1] addr = '0;
    logic        mcd212_ack = 1'b0, dtackslaven = 1'b1;
    logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq;

    int vec = 0, bad = 0, cur_n = 0;
    logic [6:0] obs [0:511];
    logic [6:0] expv[0:511];

    attex_bus_ctrl #(.FIXED_WAIT(FW), .TIMEOUT(TMO), .IRQ_DELAY(IRQD)) dut (
        .clk(clk), .reset(reset), .as(as), .uds(uds), .lds(lds), .write_strobe(write_strobe),
        .addr(addr), .mcd212_ack(mcd212_ack), .dtackslaven(dtackslaven),
        .cs_mcd212(cs_mcd212), .cs_cdic(cs_cdic), .cs_slave(cs_slave), .cs_nvram(cs_nvram),
        .bus_ack(bus_ack), .bus_err(bus_err), .slave_irq(slave_irq)
    );

    always #5 clk = ~clk;

    // Region classes: 0 none, 1 error map, 2 cdic, 3 slave, 4 nvram, 5 mcd212
    function automatic int classify(input logic [23:0] a);
        if ((a >= 24'h600000 && a < 24'hD00000) || a >= 24'hF00000) return 1;
        if (a[23:16] == 8'h30) return 2;
        if (a[23:16] == 8'h31) return 3;
        if (a[23:16] == 8'h32) return 4;
        if ((a <= 24'h27FFFF || a >= 24'h400000) && a < 24'h800000) return 5;
        return 0;
    endfunction

    // Cycle 0 = cycle in which as is first driven; compute when the cycle completes and what the CPU sees
    task automatic model(input logic [23:0] a, input int mack, input int dt_lo, input int dt_hi,
                         input int drop, input int n);
        int t = classify(a);
        int c, m, last;
        bit ok, ab;
        logic [3:0] csv;
        m = (mack < 2) ? 2 : mack;
        if (t == 1) begin c = 2; ok = 0; end
        else if (t == 2 || t == 4) begin c = 2 + FW; ok = 1; end
        else if (t == 5 && mack >= 0 && m <= 1 + TMO) begin c = m + 1; ok = 1; end
        else if (t == 3 && dt_lo < dt_hi && dt_hi >= 2 && dt_hi <= 1 + TMO) begin c = dt_hi + 1; ok = 1; end
        else begin c = 2 + TMO; ok = 0; end
        ab   = drop <= c - 1;
        last = ab ? drop : (drop > c ? drop : c + 1);
        csv  = t == 5 ? 4'b1000 : t == 2 ? 4'b0100 : t == 3 ? 4'b0010 : t == 4 ? 4'b0001 : 4'b0000;
        for (int k = 0; k <= n; k++)
            expv[k] = {(k >= 2 && k <= last) ? csv : 4'b0000, !ab && k == c && ok, !ab && k == c && !ok,
                       t == 3 && last >= 2 && k == 2 + IRQD};
    endtask

    task automatic run(input logic [23:0] a, input int mack, input int dt_lo, input int dt_hi,
                       input int drop, input int gap);
        int n = drop + gap;
        if (classify(a) == 3 && n < IRQD + 3) n = IRQD + 3;
        cur_n = n;
        model(a, mack, dt_lo, dt_hi, drop, n);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            obs[k] = {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq};
            as = k < drop;
            {uds, lds} = as ? 2'($urandom_range(1, 3)) : 2'($urandom);
            write_strobe = 1'($urandom);
            addr = a[23:1];
            mcd212_ack = mack >= 0 && k >= mack && k < drop;
            dtackslaven = !(k >= dt_lo && k < dt_hi);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; as = 1'b1; uds = 1'b1; addr = 23'h000200; mcd212_ack = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if ({cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq} !== 7'b0) begin
            bad++; $display("FAIL reset_hold got %b exp 0000000",
                            {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq});
        end
        reset = 1'b1; as = 1'b0; mcd212_ack = 1'b0;
        @(negedge clk);
        vec++;
        if ({cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq} !== 7'b0) begin
            bad++; $display("FAIL reset_release got %b exp 0000000",
                            {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq});
        end
    endtask

    task automatic test_cdic_nvram;
        logic [23:0] ad[3] = '{24'h300010, 24'h320000, 24'h30FFFE};
        int dr[3] = '{7, 6, 4};
        for (int i = 0; i < 3; i++) begin
            run(ad[i], -1, 1000, 1000, dr[i], 2);
            for (int k = 0; k <= cur_n; k++) begin
                vec++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL fixed_wait a=%h cyc %0d got %b exp %b", ad[i], k, obs[k], expv[k]); end
            end
        end
    endtask

    task automatic test_mcd212;
        logic [23:0] ad[4] = '{24'h000400, 24'h280000, 24'h27FFFE, 24'h400000};
        int mk[4] = '{5, 3, 2, 0};
        int dr[4] = '{9, 260, 6, 5};
        for (int i = 0; i < 4; i++) begin
            run(ad[i], mk[i], 1000, 1000, dr[i], 2);
            for (int k = 0; k <= cur_n; k++) begin
                vec++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL mcd212 a=%h cyc %0d got %b exp %b", ad[i], k, obs[k], expv[k]); end
            end
        end
    endtask

    task automatic test_slave;
        int lo[3] = '{4, 1000, 2};
        int hi[3] = '{7, 1000, 3};
        int dr[3] = '{10, 260, 9};
        for (int i = 0; i < 3; i++) begin
            run(24'h310002, -1, lo[i], hi[i], dr[i], 2);
            for (int k = 0; k <= cur_n; k++) begin
                vec++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL slave #%0d cyc %0d got %b exp %b", i, k, obs[k], expv[k]); end
            end
        end
    endtask

    task automatic test_errmap;
        logic [23:0] ad[4] = '{24'h700000, 24'hF00000, 24'h600000, 24'hCFFFFE};
        for (int i = 0; i < 4; i++) begin
            run(ad[i], 1, 1000, 1000, 5, 2);
            for (int k = 0; k <= cur_n; k++) begin
                vec++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL errmap a=%h cyc %0d got %b exp %b", ad[i], k, obs[k], expv[k]); end
            end
        end
    endtask

    task automatic test_abort;
        logic [23:0] ad[4] = '{24'h000400, 24'h300010, 24'h310000, 24'h000400};
        int dr[4] = '{4, 3, 5, 1};
        for (int i = 0; i < 4; i++) begin
            run(ad[i], -1, 1000, 1000, dr[i], 2);
            for (int k = 0; k <= cur_n; k++) begin
                vec++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL abort a=%h cyc %0d got %b exp %b", ad[i], k, obs[k], expv[k]); end
            end
        end
    endtask

    task automatic test_ack_timeout_race;
        int mk[2] = '{1 + TMO, 2 + TMO};
        for (int i = 0; i < 2; i++) begin
            run(24'h000400, mk[i], 1000, 1000, TMO + 5, 2);
            for (int k = 0; k <= cur_n; k++) begin
                vec++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL ack_vs_timeout mack=%0d cyc %0d got %b exp %b", mk[i], k, obs[k], expv[k]); end
            end
        end
    endtask

    task automatic test_async_reset;
        logic [23:0] a = 24'h300010;
        @(negedge clk);
        as = 1'b1; {uds, lds} = 2'b11; addr = a[23:1];
        repeat (2) @(negedge clk);
        vec++;
        if (cs_cdic !== 1'b1) begin bad++; $display("FAIL async_reset_pre cs_cdic got %b exp 1", cs_cdic); end
        #2 reset = 1'b0;
        #1;
        vec++;
        if ({cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq} !== 7'b0) begin
            bad++; $display("FAIL async_reset got %b exp 0000000",
                            {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq});
        end
        @(negedge clk);
        as = 1'b0; reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            vec++;
            if ({cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq} !== 7'b0) begin
                bad++; $display("FAIL async_reset_after got %b exp 0000000",
                                {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, slave_irq});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] ad[5] = '{24'h300010, 24'h700000, 24'h000400, 24'h320000, 24'hF00000};
        int mk[5] = '{-1, -1, 3, -1, -1};
        int dr[5] = '{5, 3, 5, 5, 3};
        for (int i = 0; i < 5; i++) begin
            run(ad[i], mk[i], 1000, 1000, dr[i], 0);
            for (int k = 0; k <= cur_n; k++) begin
                vec++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL back_to_back a=%h cyc %0d got %b exp %b", ad[i], k, obs[k], expv[k]); end
            end
        end
    endtask

    task automatic test_random;
        logic [23:0] base[8] = '{24'h000000, 24'h300000, 24'h310000, 24'h320000,
                                 24'h600000, 24'hF00000, 24'h280000, 24'h400000};
        for (int i = 0; i < 40; i++) begin
            logic [23:0] a = base[$urandom_range(0, 7)] + {8'h0, 16'($urandom) & 16'hFFFE};
            int mk = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 10));
            int lo = $urandom_range(0, 5);
            int hi = lo + int'($urandom_range(0, 6));
            int dr = $urandom_range(1, 14);
            run(a, mk, lo, hi, dr, 2);
            for (int k = 0; k <= cur_n; k++) begin
                vec++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL random a=%h mack=%0d dt=%0d..%0d drop=%0d cyc %0d got %b exp %b", a, mk, lo, hi, dr, k, obs[k], expv[k]); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_cdic_nvram;
        test_mcd212;
        test_slave;
        test_errmap;
        test_abort;
        test_ack_timeout_race;
        test_async_reset;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim time exceeded, %0d vectors applied", vec);
        $fatal(1, "watchdog");
    end
endmodule
